bsg_async_reset_sequencer: RTL and testbench
============================================

Name: bsg_async_reset_sequencer

Overview:
- Generates ordered, staggered reset signals for `els_p` downstream domains of async-reset registers. Each `reset_o` bit is active-high and drives a register bank's asynchronous reset input.
- Assertion is immediate and asynchronous on the global reset. Deassertion is synchronized, then released one domain at a time with a fixed gap.
- Software can later re-reset any subset of domains through a valid/ready handshake.
- Sits between the chip/tile reset pad logic and the register banks of the datapath.

Parameters:
- els_p, 4, number of reset domains (>=1).
- gap_cycles_p, 8, cycles between consecutive domain releases (>=1).
- hold_cycles_p, 16, cycles a software-requested reset is held before the release sequence begins (>=1).
- sync_stages_p, 2, synchronizer depth for global reset deassertion (>=2).

Ports:
- clk_i  in  1  clock
- async_reset_n_i  in  1  global reset, asynchronous, active-low
- sw_v_i  in  1  software re-reset request valid
- sw_mask_i  in  els_p  domains to re-reset; bit i = domain i
- sw_ready_o  out  1  request accepted when sw_v_i & sw_ready_o at a rising edge
- reset_o  out  els_p  per-domain reset, active-high
- done_o  out  1  all domains released, sequencer idle
- ack_i  in  els_p  per-domain reset-complete acknowledge (used only with the optional feature)

Behaviour:
- Reset is asynchronous and active-low, fixed for this block. While async_reset_n_i=0, regardless of state:
  - reset_o = all ones
  - done_o = 0, sw_ready_o = 0
  - sync chain = 0, counter = 0, stored mask = all ones, state = SYNC
- Assertion takes effect immediately, with no clock edge needed.
- Let t0 be the first rising edge with async_reset_n_i=1. The synchronizer shifts in 1s; no output changes before edge t0+sync_stages_p.
- States:
  - SYNC: waits for the synchronizer output. Then → GAP, with idx = lowest set bit of the stored mask and the counter loaded.
  - GAP: counts gap_cycles_p cycles, then clears reset_o[idx].
    - If no higher mask bit is set → DONE.
    - Otherwise idx = next higher set mask bit, counter reloads, stay in GAP.
  - DONE: done_o=1, sw_ready_o=1.
  - HOLD: counts hold_cycles_p cycles → GAP, with idx = lowest set bit of the stored mask.
- Power-up timing: reset_o[i] falls on edge t0+sync_stages_p+(i+1)*gap_cycles_p. done_o rises on the same edge that reset_o[els_p-1] falls.
- Software request accepted at edge ta (state DONE, sw_v_i=1):
  - mask != 0: on edge ta, reset_o |= mask, mask is stored, done_o and sw_ready_o fall, state → HOLD.
  - mask == 0: the handshake completes, outputs are unchanged, state stays DONE.
- Software-request timing:
  - The first masked domain falls at ta+hold_cycles_p+gap_cycles_p.
  - Each subsequent masked domain falls gap_cycles_p later, in ascending index order.
  - Unmasked domains stay 0 throughout.
  - done_o rises with the last masked release.
- sw_v_i outside DONE is ignored; no request is queued.
- sw_mask_i is sampled only at acceptance; later changes have no effect.
- Once cleared, reset_o bits change only on software acceptance or global reset.
- Global reset mid-sequence (any state) aborts and restarts from SYNC with all domains asserted.
- All outputs are registered and glitch-free. reset_o is driven directly from flops.
- Counter width: $clog2(max(gap_cycles_p,hold_cycles_p)+1).

Optional Feature:
- Macro: BSG_RESET_SEQ_ACK_EN.
- Defined:
  - After releasing domain idx, the sequencer waits in a WAIT_ACK state until ack_i[idx]=1, sampled at a rising edge.
  - Only then does the next gap count start; the transition to DONE also waits for this ack.
  - Acks of domains not being released are ignored.
  - With ack_i tied high, each step adds 1 cycle relative to the non-ack timing.
- Undefined: ack_i is unused, WAIT_ACK does not exist, and timing is exactly as in Behaviour.

Test Plan:
- Power-up: defaults, async_reset_n_i low for 5 cycles, then high at t0 → reset_o=4'b1111 until t0+10. Bit 0 falls at t0+10, bit 1 at t0+18, bit 2 at t0+26, bit 3 at t0+34 with done_o=1 on that edge.
- Asynchronous assertion: in DONE, drive async_reset_n_i low between clock edges → reset_o=4'b1111 and done_o=0 before the next edge. Release → full sequence repeats with the same timing.
- Software re-reset: in DONE, sw_v_i=1 with sw_mask_i=4'b1010 accepted at ta → reset_o=4'b1010 at ta. Bit 1 falls at ta+24, bit 3 at ta+32 with done_o=1; bits 0 and 2 stay 0 throughout.
- Handshake corners:
  - sw_v_i held during the power-up sequence → not accepted until DONE, then accepted on the first DONE edge.
  - sw_mask_i=0 → no reset_o change and done_o stays 1.
- Mid-sequence abort: global reset pulse during HOLD of a mask=4'b0001 request → all four domains asserted, full power-up sequence restarts from t0.
- With BSG_RESET_SEQ_ACK_EN defined: hold ack_i=0 → after reset_o[0] falls, reset_o[1] stays 1 indefinitely. Raise ack_i[0] at edge tk → reset_o[1] falls at tk+8.

Source files
------------

// File: rtl/bsg_async_reset_sequencer.sv
// Staggered per-domain reset generator: immediate async assertion, synchronized ordered release,
// software re-reset via valid/ready. Optional ack-gated release under BSG_RESET_SEQ_ACK_EN.
module bsg_async_reset_sequencer #(
   parameter int unsigned els_p         = 4,
   parameter int unsigned gap_cycles_p  = 8,
   parameter int unsigned hold_cycles_p = 16,
   parameter int unsigned sync_stages_p = 2
) (
   input  logic             clk_i,
   input  logic             async_reset_n_i,
   input  logic             sw_v_i,
   input  logic [els_p-1:0] sw_mask_i,
   output logic             sw_ready_o,
   output logic [els_p-1:0] reset_o,
   output logic             done_o,
   input  logic [els_p-1:0] ack_i
);

   localparam int unsigned max_cycles_lp = (gap_cycles_p > hold_cycles_p) ? gap_cycles_p : hold_cycles_p;
   localparam int unsigned cnt_w_lp      = $clog2(max_cycles_lp + 1);
   localparam int unsigned idx_w_lp      = (els_p > 1) ? $clog2(els_p) : 1;

   localparam logic [cnt_w_lp-1:0] gap_load_lp  = cnt_w_lp'(gap_cycles_p - 1);
   localparam logic [cnt_w_lp-1:0] hold_load_lp = cnt_w_lp'(hold_cycles_p - 1);

   typedef enum logic [2:0] {
      e_sync = 3'd0,
      e_gap  = 3'd1,
      e_hold = 3'd2,
      e_done = 3'd3
`ifdef BSG_RESET_SEQ_ACK_EN
      , e_wait_ack = 3'd4
`endif
   } state_e;

   state_e                state_r, state_n;
   logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
   logic [idx_w_lp-1:0]   idx_r, idx_n;
   logic [els_p-1:0]      mask_r, mask_n;
   logic [sync_stages_p-1:0] sync_r;
   logic [els_p-1:0]      reset_n;
   logic                  done_n;
   logic                  ready_n;
   logic                  release_c;
   logic                  accept_c;
   logic [idx_w_lp-1:0]   first_idx;
   logic [idx_w_lp-1:0]   next_idx;
   logic                  has_next;

`ifndef BSG_RESET_SEQ_ACK_EN
   logic unused_ack;
   assign unused_ack = ^ack_i;
`endif

   // State register; everything, including the outputs, is flopped here
   always_ff @(posedge clk_i or negedge async_reset_n_i) begin
      if (!async_reset_n_i) begin
         state_r    <= e_sync;
         cnt_r      <= '0;
         idx_r      <= '0;
         mask_r     <= '1;
         sync_r     <= '0;
         reset_o    <= '1;
         done_o     <= 1'b0;
         sw_ready_o <= 1'b0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         idx_r      <= idx_n;
         mask_r     <= mask_n;
         sync_r     <= {sync_r[sync_stages_p-2:0], 1'b1};
         reset_o    <= reset_n;
         done_o     <= done_n;
         sw_ready_o <= ready_n;
      end
   end

   // Lowest set bit of the stored mask, and the next set bit above the current domain
   always_comb begin
      first_idx = '0;
      next_idx  = idx_r;
      has_next  = 1'b0;
      for (int i = int'(els_p) - 1; i >= 0; i--) begin
         if (mask_r[i]) begin
            first_idx = idx_w_lp'(i);
            if (idx_w_lp'(i) > idx_r) begin
               next_idx = idx_w_lp'(i);
               has_next = 1'b1;
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      idx_n     = idx_r;
      mask_n    = mask_r;
      release_c = 1'b0;
      accept_c  = 1'b0;
      case (state_r)
         e_sync: begin
            if (sync_r[sync_stages_p-1]) begin
               state_n = e_gap;
               cnt_n   = gap_load_lp;
               idx_n   = first_idx;
            end
         end
         e_gap: begin
            if (cnt_r == '0) begin
               release_c = 1'b1;
`ifdef BSG_RESET_SEQ_ACK_EN
               state_n = e_wait_ack;
`else
               if (has_next) begin
                  idx_n = next_idx;
                  cnt_n = gap_load_lp;
               end else begin
                  state_n = e_done;
               end
`endif
            end else begin
               cnt_n = cnt_r - cnt_w_lp'(1);
            end
         end
`ifdef BSG_RESET_SEQ_ACK_EN
         e_wait_ack: begin
            if (ack_i[idx_r]) begin
               if (has_next) begin
                  state_n = e_gap;
                  idx_n   = next_idx;
                  cnt_n   = gap_load_lp;
               end else begin
                  state_n = e_done;
               end
            end
         end
`endif
         e_hold: begin
            if (cnt_r == '0) begin
               state_n = e_gap;
               cnt_n   = gap_load_lp;
               idx_n   = first_idx;
            end else begin
               cnt_n = cnt_r - cnt_w_lp'(1);
            end
         end
         e_done: begin
            if (sw_v_i) begin
               accept_c = 1'b1;
               // An empty mask completes the handshake without leaving DONE
               if (|sw_mask_i) begin
                  mask_n  = sw_mask_i;
                  state_n = e_hold;
                  cnt_n   = hold_load_lp;
               end
            end
         end
         default: state_n = e_sync;
      endcase
   end

   // Output next values, registered in the state register block
   always_comb begin
      reset_n = reset_o;
      if (release_c) reset_n[idx_r] = 1'b0;
      if (accept_c)  reset_n = reset_o | sw_mask_i;
      done_n  = (state_n == e_done);
      ready_n = (state_n == e_done);
   end

endmodule

// File: tb/tb_bsg_async_reset_sequencer.sv
// Scoreboard bench for bsg_async_reset_sequencer: stimulus queues expected output events,
// a negedge monitor pops one whenever reset_o/done_o/sw_ready_o change.
module tb_bsg_async_reset_sequencer;

   typedef struct {
      int         cyc;
      logic [3:0] rst;
      logic       done;
      logic       rdy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_v = 1'b0;
   logic [3:0] sw_mask = 4'b0000;
   logic [3:0] ack = 4'b0000;
   logic       sw_ready;
   logic [3:0] reset_o;
   logic       done;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         evt = 0;
   logic       fin = 1'b0;
   logic [5:0] prev = 6'bxxxxxx;
   exp_t       q[$];

   bsg_async_reset_sequencer #(
      .els_p(4), .gap_cycles_p(8), .hold_cycles_p(16), .sync_stages_p(2)
   ) dut (
      .clk_i(clk),
      .async_reset_n_i(rst_n),
      .sw_v_i(sw_v),
      .sw_mask_i(sw_mask),
      .sw_ready_o(sw_ready),
      .reset_o(reset_o),
      .done_o(done),
      .ack_i(ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every change of the observed outputs must match the next queued expectation
   always @(negedge clk) begin
      logic [5:0] cur;
      exp_t       e;
      cur = {reset_o, done, sw_ready};
      if (cur !== prev) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got cyc %0d reset %b done %b ready %b, required no change",
                     cyc, reset_o, done, sw_ready);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || cur !== {e.rst, e.done, e.rdy}) begin
               errors++;
               $display("FAIL evt_%0d: got cyc %0d reset %b done %b ready %b, required cyc %0d reset %b done %b ready %b",
                        evt, cyc, reset_o, done, sw_ready, e.cyc, e.rst, e.done, e.rdy);
            end
         end
         evt++;
         prev = cur;
      end
      if (fin) begin
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d events still pending, required 0", q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   task automatic push(input int c, input logic [3:0] r, input logic d);
      exp_t e;
      e.cyc  = c;
      e.rst  = r;
      e.done = d;
      e.rdy  = d;
      q.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic push_powerup(input int t0);
      push(t0 + 10, 4'b1110, 1'b0);
      push(t0 + 18, 4'b1100, 1'b0);
      push(t0 + 26, 4'b1000, 1'b0);
      push(t0 + 34, 4'b0000, 1'b1);
   endtask

   initial begin
      int t0;
      int ta;
      // Reset state seen at the first sample
      push(1, 4'b1111, 1'b0);
      repeat (5) step();

      // Power-up release sequence
      rst_n = 1'b1;
      t0 = cyc + 1;
      push_powerup(t0);
      step_to(t0 + 36);

      // Asynchronous assertion between edges, visible before the next edge
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      push(cyc, 4'b1111, 1'b0);
      repeat (3) step();

      // Restart with a request held throughout; accepted on the first DONE edge
      rst_n   = 1'b1;
      sw_v    = 1'b1;
      sw_mask = 4'b1010;
      t0 = cyc + 1;
      push_powerup(t0);
      ta = t0 + 35;
      push(ta,      4'b1010, 1'b0);
      push(ta + 24, 4'b1000, 1'b0);
      push(ta + 32, 4'b0000, 1'b1);
      step_to(ta);
      sw_v    = 1'b0;
      sw_mask = 4'b0101;
      step_to(ta + 34);

      // Empty mask: handshake completes, nothing changes
      sw_v    = 1'b1;
      sw_mask = 4'b0000;
      step();
      sw_v = 1'b0;
      repeat (3) step();

      // Request domain 0, then abort with a global reset during HOLD
      sw_v    = 1'b1;
      sw_mask = 4'b0001;
      push(cyc + 1, 4'b0001, 1'b0);
      step();
      sw_v    = 1'b0;
      sw_mask = 4'b0000;
      repeat (5) step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      push(cyc, 4'b1111, 1'b0);
      repeat (2) step();
      rst_n = 1'b1;
      t0 = cyc + 1;
      push_powerup(t0);
      step_to(t0 + 40);
      fin = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
